// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M unit: shift-add multiplier and restoring divider, one bit per cycle.
// Holds the final result until MA accepts it; flush aborts any operation in flight.
module ex_muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    input  logic            ma_stall_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic [XLEN-1:0]     op_q, op_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic                neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand decode at accept time
    logic            a_signed, b_signed, in_neg_a, in_neg_b;
    logic [XLEN-1:0] mag_a, mag_b, special_res;
    logic            is_div_in, div_zero, div_ovf, special;

    assign a_signed  = (funct3_i == 3'd1) || (funct3_i == 3'd2) ||
                       (funct3_i == 3'd4) || (funct3_i == 3'd6);
    assign b_signed  = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
    assign in_neg_a  = a_signed & rs1_i[XLEN-1];
    assign in_neg_b  = b_signed & rs2_i[XLEN-1];
    assign mag_a     = in_neg_a ? -rs1_i : rs1_i;
    assign mag_b     = in_neg_b ? -rs2_i : rs2_i;
    assign is_div_in = funct3_i[2];
    assign div_zero  = is_div_in & (rs2_i == '0);
    assign div_ovf   = is_div_in & ~funct3_i[0] & (rs1_i == INT_MIN) & (rs2_i == '1);
    assign special   = div_zero | div_ovf;
    assign special_res = div_zero ? (funct3_i[1] ? rs1_i : '1)
                                  : (funct3_i[1] ? '0 : INT_MIN);

    // Multiply step: product shifts right, multiplier bits consumed from the low half
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, op_q};
    assign mul_step = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]}
                                : {1'b0, prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1:1]};

    // Divide step: {remainder, dividend/quotient} shifts left, quotient bit enters at LSB
    logic [XLEN:0]     rem_sh, rem_diff;
    logic              rem_ge;
    logic [2*XLEN-1:0] div_step;
    assign rem_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, op_q};
    assign rem_ge   = rem_sh >= {1'b0, op_q};
    assign div_step = {rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0],
                       prod_q[XLEN-2:0], rem_ge};

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_mag, rem_mag, quo_fix, rem_fix, fix_res;
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
    assign quo_mag  = prod_q[XLEN-1:0];
    assign rem_mag  = prod_q[2*XLEN-1:XLEN];
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -quo_mag : quo_mag;
    assign rem_fix  = neg_a_q ? -rem_mag : rem_mag;
    assign fix_res  = f3_q[2] ? (f3_q[1] ? rem_fix : quo_fix)
                              : ((f3_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        op_d     = op_q;
        prod_d   = prod_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        done_d   = done_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    f3_d    = funct3_i;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    cnt_d   = '0;
                    if (special) begin
                        result_d = special_res;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        op_d    = is_div_in ? mag_b : mag_a;
                        prod_d  = {{XLEN{1'b0}}, is_div_in ? mag_a : mag_b};
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                cnt_d  = cnt_q + CNT_W'(1);
                prod_d = f3_q[2] ? div_step : mul_step;
                if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_res;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (!ma_stall_i) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush aborts from any state and leaves the last result in place
        if (flush_i) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            op_q     <= '0;
            prod_q   <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            op_q     <= op_d;
            prod_q   <= prod_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = rst_ni & (((state_q == S_IDLE) & start_i & ~flush_i & ~special) |
                                (state_q == S_CALC) | (state_q == S_FIX));
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
